// File: rtl/clint_timer_ctrl.sv
// rtl/clint_timer_ctrl.sv - MMIO mtime/mtimecmp timer with registered level timer interrupt.
// Optional msip register and soft_int_o are enabled by defining CLINT_TIMER_MSIP_EN.
module clint_timer_ctrl #(
  parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_BFF8,
  parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000,
  parameter logic [63:0] MSIP_ADDR     = 64'h0000_0000_0200_0000,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_wen_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [7:0]  req_wmask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [63:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [63:0] mtime_o,
  output logic        timer_int_o,
  output logic        soft_int_o
);

  typedef enum logic {IDLE, RESP} state_e;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        timer_int_q, timer_int_d;

  logic        aligned, hit_mtime, hit_cmp, hit_msip, mapped, tick, do_write;
  logic [63:0] bmask, rd_val;

`ifdef CLINT_TIMER_MSIP_EN
  logic msip_q, msip_d;
`else
  logic unused_msip_addr;
  assign unused_msip_addr = ^MSIP_ADDR;
`endif

  assign aligned   = (req_addr_i[2:0] == 3'b000);
  assign hit_mtime = aligned && (req_addr_i == MTIME_ADDR);
  assign hit_cmp   = aligned && (req_addr_i == MTIMECMP_ADDR);
`ifdef CLINT_TIMER_MSIP_EN
  assign hit_msip  = aligned && (req_addr_i == MSIP_ADDR);
`else
  assign hit_msip  = 1'b0;
`endif
  assign mapped    = hit_mtime | hit_cmp | hit_msip;
  assign tick      = (presc_q == PRESC_MAX);
  assign do_write  = (state_q == IDLE) && req_valid_i && req_wen_i && mapped && (|req_wmask_i);

  always_comb begin
    bmask = '0;
    for (int i = 0; i < 8; i++) begin
      bmask[i*8 +: 8] = {8{req_wmask_i[i]}};
    end
  end

  always_comb begin
    rd_val = '0;
    if (hit_mtime) rd_val = mtime_q;
    if (hit_cmp)   rd_val = mtimecmp_q;
`ifdef CLINT_TIMER_MSIP_EN
    if (hit_msip)  rd_val = {63'b0, msip_q};
`endif
  end

  always_comb begin
    state_d     = state_q;
    presc_d     = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d     = mtime_q + {63'b0, tick};
    mtimecmp_d  = mtimecmp_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    timer_int_d = (mtime_q >= mtimecmp_q);
`ifdef CLINT_TIMER_MSIP_EN
    msip_d      = msip_q;
`endif

    // A software write to mtime overrides the same-cycle increment.
    if (do_write && hit_mtime) mtime_d    = (mtime_q & ~bmask) | (req_wdata_i & bmask);
    if (do_write && hit_cmp)   mtimecmp_d = (mtimecmp_q & ~bmask) | (req_wdata_i & bmask);
`ifdef CLINT_TIMER_MSIP_EN
    if (do_write && hit_msip && req_wmask_i[0]) msip_d = req_wdata_i[0];
`endif

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d     = RESP;
          rsp_err_d   = ~mapped;
          rsp_rdata_d = (!req_wen_i && mapped) ? rd_val : 64'd0;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      presc_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      timer_int_q <= 1'b0;
`ifdef CLINT_TIMER_MSIP_EN
      msip_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      presc_q     <= presc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      timer_int_q <= timer_int_d;
`ifdef CLINT_TIMER_MSIP_EN
      msip_q      <= msip_d;
`endif
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mtime_o     = mtime_q;
  assign timer_int_o = timer_int_q;
`ifdef CLINT_TIMER_MSIP_EN
  assign soft_int_o  = msip_q;
`else
  assign soft_int_o  = 1'b0;
`endif

endmodule
